mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Consumes the execute outputs (write-back/memory control, ALU result, store data, branch target, destination register) and performs word loads and stores against an internal data memory. Resolves the branch decision. Registers everything the write-back stage needs in the MEM/WB pipeline latch.

---
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of a five-stage MIPS pipeline. It sits directly
//   downstream of the execute stage and does three jobs:
//     - performs word loads and stores against an internal data memory,
//     - resolves the branch decision combinationally for the PC mux,
//     - registers everything write-back needs in the MEM/WB latch.
//
// Parameters
//   DEPTH           data memory size in 32-bit words (power of two, >= 4)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset (clears the MEM/WB latch only)
//   valid_in        execute output holds a real instruction (0 = bubble)
//   ctlwb_in[1:0]   write-back control: [1] regwrite, [0] memtoreg
//   ctlm_in[1:0]    memory control: [1] memread, [0] memwrite
//   branch          instruction is a conditional branch
//   zero            ALU zero flag
//   adder_in        branch target computed in execute
//   alu_result      ALU result, also the byte address for loads/stores
//   rdata2          store data
//   muxout_in       destination register number
//   pcsrc           take the branch (combinational)
//   branch_target   branch target, equal to adder_in (combinational)
//   valid_out       MEM/WB latch holds a real instruction
//   ctlwb_out       latched write-back control
//   read_data_out   latched load data
//   alu_result_out  latched ALU result
//   muxout_out      latched destination register
//   misalign_err    latched flag: the previous access was misaligned
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [1:0]  ctlwb_in,
  input  logic [1:0]  ctlm_in,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] adder_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  muxout_in,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        valid_out,
  output logic [1:0]  ctlwb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  muxout_out,
  output logic        misalign_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Data memory. Contents start at zero and are deliberately left out of the
  // reset: a pipeline reset must not wipe architectural memory state.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic              memread;
  logic              memwrite;
  logic              access_en;
  logic              misaligned;
  logic              do_store;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       load_data;

  // Address bits above the word index are ignored so the memory wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^alu_result[31:ADDR_W+2];

  assign memread    = ctlm_in[1];
  assign memwrite   = ctlm_in[0];
  assign word_idx   = alu_result[ADDR_W+1:2];
  assign access_en  = valid_in & (memread | memwrite);
  assign misaligned = access_en & (alu_result[1:0] != 2'b00);

  // Stores are also inhibited while reset is held, even though the memory
  // itself has no reset.
  assign do_store = rst_n & valid_in & memwrite & ~misaligned;

  // Combinational read of the current contents; because the write below only
  // lands at the clock edge, a same-cycle read+write naturally returns the
  // pre-store word.
  assign load_data = (valid_in & memread & ~misaligned) ? mem[word_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[word_idx] <= rdata2;
    end
  end

  // Branch resolution is combinational so the PC mux sees it this cycle.
  assign pcsrc         = branch & zero & valid_in;
  assign branch_target = adder_in;

  // MEM/WB latch. A bubble forces control, valid and error to zero (load data
  // is already zero for a bubble) while address and destination still pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out      <= 1'b0;
      ctlwb_out      <= 2'b00;
      read_data_out  <= 32'h0;
      alu_result_out <= 32'h0;
      muxout_out     <= 5'd0;
      misalign_err   <= 1'b0;
    end else begin
      valid_out      <= valid_in;
      ctlwb_out      <= valid_in ? ctlwb_in : 2'b00;
      read_data_out  <= load_data;
      alu_result_out <= alu_result;
      muxout_out     <= muxout_in;
      misalign_err   <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [1:0]  ctlwb_in;
  logic [1:0]  ctlm_in;
  logic        branch;
  logic        zero;
  logic [31:0] adder_in;
  logic [31:0] alu_result;
  logic [31:0] rdata2;
  logic [4:0]  muxout_in;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        valid_out;
  logic [1:0]  ctlwb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  muxout_out;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  mem_stage #(.DEPTH(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .ctlwb_in       (ctlwb_in),
    .ctlm_in        (ctlm_in),
    .branch         (branch),
    .zero           (zero),
    .adder_in       (adder_in),
    .alu_result     (alu_result),
    .rdata2         (rdata2),
    .muxout_in      (muxout_in),
    .pcsrc          (pcsrc),
    .branch_target  (branch_target),
    .valid_out      (valid_out),
    .ctlwb_out      (ctlwb_out),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .muxout_out     (muxout_out),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: wait for the edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] m,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    valid_in   = v;
    ctlwb_in   = wb;
    ctlm_in    = m;
    alu_result = addr;
    rdata2     = wd;
    muxout_in  = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    adder_in = 32'h0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #12;
    chk("reset_valid", {31'h0, valid_out}, 32'h0);
    chk("reset_ctlwb", {30'h0, ctlwb_out}, 32'h0);
    chk("reset_rdata", read_data_out, 32'h0);
    chk("reset_alu", alu_result_out, 32'h0);
    chk("reset_mux", {27'h0, muxout_out}, 32'h0);
    chk("reset_misalign", {31'h0, misalign_err}, 32'h0);
    rst_n = 1'b1;

    // Store then load
    drive(1'b1, 2'b00, 2'b01, 32'h10, 32'hDEADBEEF, 5'd0);
    step();
    $display("store 0x10 <= DEADBEEF");
    chk("store_valid", {31'h0, valid_out}, 32'h1);
    chk("store_rdata", read_data_out, 32'h0);
    drive(1'b1, 2'b11, 2'b10, 32'h10, 32'h0, 5'd7);
    step();
    $display("load 0x10 -> %h", read_data_out);
    chk("load_rdata", read_data_out, 32'hDEADBEEF);
    chk("load_ctlwb", {30'h0, ctlwb_out}, 32'h3);
    chk("load_valid", {31'h0, valid_out}, 32'h1);
    chk("load_mux", {27'h0, muxout_out}, 32'd7);
    chk("load_alu", alu_result_out, 32'h10);

    // Simultaneous read + write
    drive(1'b1, 2'b00, 2'b01, 32'hC, 32'h11111111, 5'd0);
    step();
    drive(1'b1, 2'b11, 2'b11, 32'hC, 32'h22222222, 5'd3);
    step();
    $display("rw 0xC -> %h", read_data_out);
    chk("rw_old", read_data_out, 32'h11111111);
    drive(1'b1, 2'b11, 2'b10, 32'hC, 32'h0, 5'd3);
    step();
    $display("load 0xC -> %h", read_data_out);
    chk("rw_new", read_data_out, 32'h22222222);

    // Address wrap
    drive(1'b1, 2'b00, 2'b01, 32'h400, 32'hA5A5A5A5, 5'd0);
    step();
    drive(1'b1, 2'b11, 2'b10, 32'h0, 32'h0, 5'd1);
    step();
    $display("load 0x0 after store 0x400 -> %h", read_data_out);
    chk("wrap_rdata", read_data_out, 32'hA5A5A5A5);

    // Misaligned store, then misaligned load, then aligned load of mem[4]
    drive(1'b1, 2'b00, 2'b01, 32'h13, 32'hFFFFFFFF, 5'd0);
    step();
    $display("misaligned store 0x13 err=%0d", misalign_err);
    chk("mis_st_err", {31'h0, misalign_err}, 32'h1);
    drive(1'b1, 2'b11, 2'b10, 32'h12, 32'h0, 5'd2);
    step();
    $display("misaligned load 0x12 -> %h err=%0d", read_data_out, misalign_err);
    chk("mis_ld_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_ld_rdata", read_data_out, 32'h0);
    drive(1'b1, 2'b11, 2'b10, 32'h10, 32'h0, 5'd2);
    step();
    $display("load 0x10 -> %h err=%0d", read_data_out, misalign_err);
    chk("mis_clear", {31'h0, misalign_err}, 32'h0);
    chk("mis_mem4", read_data_out, 32'hDEADBEEF);

    // Bubble with memwrite and a would-be taken branch
    drive(1'b0, 2'b10, 2'b01, 32'h20, 32'h12345678, 5'd9);
    branch = 1'b1;
    zero = 1'b1;
    #1;
    chk("bubble_pcsrc", {31'h0, pcsrc}, 32'h0);
    step();
    $display("bubble ctlwb=%b valid=%0d", ctlwb_out, valid_out);
    chk("bubble_ctlwb", {30'h0, ctlwb_out}, 32'h0);
    chk("bubble_valid", {31'h0, valid_out}, 32'h0);
    chk("bubble_alu", alu_result_out, 32'h20);
    chk("bubble_mux", {27'h0, muxout_out}, 32'd9);
    branch = 1'b0;
    zero = 1'b0;
    drive(1'b1, 2'b11, 2'b10, 32'h20, 32'h0, 5'd9);
    step();
    $display("load 0x20 -> %h", read_data_out);
    chk("bubble_mem8", read_data_out, 32'h0);

    // Branch resolution, zero latency
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    branch = 1'b1;
    zero = 1'b1;
    adder_in = 32'd100;
    #1;
    $display("branch zero=1 pcsrc=%0d target=%0d", pcsrc, branch_target);
    chk("br_taken", {31'h0, pcsrc}, 32'h1);
    chk("br_target", branch_target, 32'd100);
    zero = 1'b0;
    #1;
    $display("branch zero=0 pcsrc=%0d", pcsrc);
    chk("br_not_taken", {31'h0, pcsrc}, 32'h0);
    branch = 1'b0;

    // Asynchronous reset between edges
    drive(1'b1, 2'b11, 2'b10, 32'h10, 32'h0, 5'd4);
    step();
    chk("pre_rst_rdata", read_data_out, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset rdata=%h valid=%0d", read_data_out, valid_out);
    chk("arst_rdata", read_data_out, 32'h0);
    chk("arst_valid", {31'h0, valid_out}, 32'h0);
    chk("arst_ctlwb", {30'h0, ctlwb_out}, 32'h0);
    chk("arst_alu", alu_result_out, 32'h0);
    chk("arst_mux", {27'h0, muxout_out}, 32'h0);
    // Store attempted while reset is held must not land
    drive(1'b1, 2'b00, 2'b01, 32'h10, 32'h0BADF00D, 5'd0);
    step();
    chk("arst_hold_alu", alu_result_out, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 2'b11, 2'b10, 32'h10, 32'h0, 5'd4);
    step();
    $display("post-reset load 0x10 -> %h", read_data_out);
    chk("post_rst_rdata", read_data_out, 32'hDEADBEEF);
    chk("post_rst_valid", {31'h0, valid_out}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
